kbd_cmd_queue: RTL and testbench
================================

KBD_CMD_QUEUE -- requirements
Module: kbd_cmd_queue

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: en  in  1  global enable; gates event capture only.
REQ-004 SHALL have port: scancode  in  8  last released-key code from the PS/2 receiver.
REQ-005 SHALL have port: f0  in  1  receiver release-pending flag; its 1->0 transition marks a completed key release.
REQ-006 SHALL have port: cmd  out  3  command code at the FIFO head.
REQ-007 SHALL have port: cmd_valid  out  1  high when cmd holds a queued command.
REQ-008 SHALL have port: cmd_ready  in  1  consumer (shape/display controller) accepts the head.
REQ-009 SHALL have port: count  out  3  FIFO occupancy, 0..4.
REQ-010 SHALL have port: ovf  out  1  sticky overflow flag.

Function
REQ-011 SHALL register f0 every cycle into f0_q, regardless of en.
REQ-012 SHALL detect a release event in cycle t when f0_q==1, f0==0 and en==1; scancode is sampled in that same cycle.
REQ-013 SHALL map the sampled scancode to cmd: 0x75->1 H_UP, 0x72->2 H_DN, 0x6B->3 W_UP, 0x74->4 W_DN, 0x2B->5 FLASH, 0x2D->6 INVERT.
REQ-014 SHALL drop any other scancode: no push, no flag change.
REQ-015 SHALL push a mapped command at the clock edge ending cycle t; cmd 0 and 7 are never produced.
REQ-016 SHALL implement a 4-entry first-word-fall-through FIFO, so cmd/cmd_valid reflect a push into an empty FIFO at edge t+1 (one-cycle latency).
REQ-017 SHALL pop on a clock edge where cmd_valid && cmd_ready; cmd_ready with cmd_valid low has no effect.
REQ-018 SHALL hold cmd stable while cmd_valid==1 and cmd_ready==0.
REQ-019 SHALL, on simultaneous push and pop with count 1..4, perform both and leave count unchanged, the pushed entry going to the tail.
REQ-020 SHALL, on a push with count==0, make the entry the head; no same-cycle pop occurs.
REQ-021 SHALL drop a push when count==4 and no pop occurs that edge; FIFO contents are unchanged.
REQ-022 SHALL keep pops operating while en==0.
REQ-023 SHALL hold cmd at 0 when cmd_valid==0.
REQ-024 SHALL wrap read and write pointers modulo 4; count is derived consistently with the pointers.

Reset
REQ-025 SHALL, on reset, set: f0_q=0, pointers=0, count=0, cmd_valid=0, cmd=0, ovf=0.
REQ-026 SHALL give reset priority over simultaneous push or pop; queued entries are discarded.
REQ-027 SHALL not produce an event in the first cycle after reset, since f0_q==0.

Configuration
REQ-028 SHALL, with KBD_CMD_OVF_EN defined, set ovf=1 on any dropped push (REQ-021) and hold it until reset.
REQ-029 SHALL, without KBD_CMD_OVF_EN, keep the ovf port and tie it to 0; drop behaviour is unchanged.

Structure
REQ-030 SHALL place in shared package kbd_cmd_pkg: command enum (NONE, H_UP, H_DN, W_UP, W_DN, FLASH, INVERT), the six scancode constants, and KBD_CMD_DEPTH=4.
REQ-031 SHALL implement the storage as one sub-module, kbd_cmd_fifo (FWFT, push/pop/count, full/empty), instantiated once; edge detection and decode stay in kbd_cmd_queue.

Verification
REQ-032 SHALL cover: scancode=0x75, f0 1->0, cmd_ready=0 -> next edge cmd_valid=1, cmd=1, count=1.
REQ-033 SHALL cover: scancode=0x1C release -> no push, count=0, cmd_valid=0.
REQ-034 SHALL cover: releases 0x72, 0x6B, 0x74, 0x2B, 0x2D with cmd_ready=0 -> count=4, head cmd=2; 5th (0x2D) dropped; ovf=1 with macro, 0 without; draining yields 2, 3, 4, 5.
REQ-035 SHALL cover: count=4, push 0x75 and cmd_ready=1 on the same edge -> count stays 4, tail=1.
REQ-036 SHALL cover: f0 falls while en=0 -> no push; raising en later creates no event.
REQ-037 SHALL cover: reset asserted with count=3 and ovf=1 -> next edge count=0, cmd_valid=0, cmd=0, ovf=0.

Source files
------------

// File: rtl/kbd_cmd_pkg.sv
// Shared definitions for the keyboard command queue: command codes,
// PS/2 scancodes that map to commands, FIFO sizing and the decoder.
package kbd_cmd_pkg;

  localparam int KBD_CMD_DEPTH = 4;
  localparam int PTR_W         = 2;
  localparam int CNT_W         = 3;
  localparam int CMD_W         = 3;
  localparam int DATA_W        = 8;

  typedef enum logic [CMD_W-1:0] {
    NONE   = 3'd0,
    H_UP   = 3'd1,
    H_DN   = 3'd2,
    W_UP   = 3'd3,
    W_DN   = 3'd4,
    FLASH  = 3'd5,
    INVERT = 3'd6
  } kbd_cmd_e;

  localparam logic [DATA_W-1:0] SC_H_UP   = 8'h75;
  localparam logic [DATA_W-1:0] SC_H_DN   = 8'h72;
  localparam logic [DATA_W-1:0] SC_W_UP   = 8'h6B;
  localparam logic [DATA_W-1:0] SC_W_DN   = 8'h74;
  localparam logic [DATA_W-1:0] SC_FLASH  = 8'h2B;
  localparam logic [DATA_W-1:0] SC_INVERT = 8'h2D;

  // Unknown scancodes decode to NONE, which the caller treats as "no push".
  function automatic kbd_cmd_e decode_scancode(input logic [DATA_W-1:0] sc);
    kbd_cmd_e c;
    c = NONE;
    case (sc)
      SC_H_UP:   c = H_UP;
      SC_H_DN:   c = H_DN;
      SC_W_UP:   c = W_UP;
      SC_W_DN:   c = W_DN;
      SC_FLASH:  c = FLASH;
      SC_INVERT: c = INVERT;
      default:   c = NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// Four-entry first-word-fall-through FIFO. The head entry is visible on
// head while valid is high; a pop on a full FIFO frees a slot for a
// same-edge push. Storage itself is not reset; only pointers and count are.
module kbd_cmd_fifo
  import kbd_cmd_pkg::*;
#(
  parameter int DATA_W = CMD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [KBD_CMD_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count_q == CNT_W'(0));
  assign full    = (count_q == CNT_W'(KBD_CMD_DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  // Pointer and occupancy tracking; pointers wrap naturally at 2 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = !empty;
  assign count = count_q;

endmodule

// File: rtl/kbd_cmd_queue.sv
// Keyboard command queue: detects completed PS/2 key releases, decodes the
// released scancode into a shape/display command and queues it for the
// consumer. Optional feature macro: KBD_CMD_OVF_EN (sticky overflow flag).
module kbd_cmd_queue
  import kbd_cmd_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] scancode,
  input  logic              f0,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  logic             f0_q;
  logic             release_ev;
  kbd_cmd_e         decoded;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic             head_valid;

  // Previous f0 level, tracked even while disabled so re-enabling cannot fake an edge.
  always_ff @(posedge clock) begin
    if (reset) f0_q <= 1'b0;
    else       f0_q <= f0;
  end

  // Stage p0: falling edge of f0 marks a finished release; decode same cycle.
  assign release_ev = f0_q && !f0 && en;
  assign decoded    = decode_scancode(scancode);
  assign push       = release_ev && (decoded != NONE);
  assign pop        = cmd_ready && head_valid;

  kbd_cmd_fifo #(
    .DATA_W (CMD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (decoded),
    .pop       (pop),
    .head      (head),
    .valid     (head_valid),
    .count     (count)
  );

  assign cmd_valid = head_valid;
  assign cmd       = head_valid ? head : CMD_W'(0);

`ifdef KBD_CMD_OVF_EN
  logic ovf_q;
  logic drop;

  // A push is dropped when the FIFO is full and the head is not leaving.
  assign drop = push && (count == CNT_W'(KBD_CMD_DEPTH)) && !pop;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_cmd_queue.sv
// Self-checking bench for kbd_cmd_queue: a queue-based reference model is
// compared against the DUT every cycle, plus literal checks at key points.
module tb_kbd_cmd_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] scancode;
  logic       f0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] count;
  logic       ovf;

  int tests = 0;
  int fails = 0;

`ifdef KBD_CMD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  kbd_cmd_queue dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .scancode  (scancode),
    .f0        (f0),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  // Reference model state
  int m_q[$];
  bit m_f0;
  bit m_ovf;

  function automatic int map_code(input logic [7:0] sc);
    case (sc)
      8'h75:   return 1;
      8'h72:   return 2;
      8'h6B:   return 3;
      8'h74:   return 4;
      8'h2B:   return 5;
      8'h2D:   return 6;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    bit do_pop;
    int c;
    if (reset) begin
      m_q.delete();
      m_f0  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      do_pop = (m_q.size() > 0) && cmd_ready;
      c = map_code(scancode);
      if (do_pop) void'(m_q.pop_front());
      if (m_f0 && !f0 && en && c != 0) begin
        if (m_q.size() < 4) m_q.push_back(c);
        else if (OVF_ON) m_ovf = 1'b1;
      end
      m_f0 = f0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every DUT output against the model.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    check("model_count", int'(count), m_q.size());
    check("model_valid", int'(cmd_valid), (m_q.size() > 0) ? 1 : 0);
    check("model_cmd", int'(cmd), (m_q.size() > 0) ? m_q[0] : 0);
    check("model_ovf", int'(ovf), int'(m_ovf));
  endtask

  task automatic key_release(input logic [7:0] code);
    scancode = code;
    f0 = 1'b1;
    step();
    f0 = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; scancode = 8'h00; f0 = 1'b0; cmd_ready = 1'b0;
    @(negedge clock);
    step();
    reset = 1'b0;
    step();
    check("reset_count", int'(count), 0);
    check("reset_valid", int'(cmd_valid), 0);
    check("reset_cmd", int'(cmd), 0);
    check("reset_ovf", int'(ovf), 0);

    // Single H_UP release, consumer stalled
    key_release(8'h75);
    check("hup_valid", int'(cmd_valid), 1);
    check("hup_cmd", int'(cmd), 1);
    check("hup_count", int'(count), 1);
    step();
    check("hup_hold_cmd", int'(cmd), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("hup_drained", int'(count), 0);

    // Unmapped scancode is ignored
    key_release(8'h1C);
    check("unmapped_count", int'(count), 0);
    check("unmapped_valid", int'(cmd_valid), 0);

    // Fill to four, then overflow
    key_release(8'h72);
    key_release(8'h6B);
    key_release(8'h74);
    key_release(8'h2B);
    check("full_count", int'(count), 4);
    check("full_head", int'(cmd), 2);
    check("full_no_ovf", int'(ovf), 0);
    key_release(8'h2D);
    check("drop_count", int'(count), 4);
    check("drop_head", int'(cmd), 2);
    check("drop_ovf", int'(ovf), OVF_ON ? 1 : 0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", int'(cmd), i + 2);
      step();
    end
    cmd_ready = 1'b0;
    check("drain_empty", int'(count), 0);
    check("drain_cmd_zero", int'(cmd), 0);

    // Push and pop on the same edge while full
    key_release(8'h72);
    key_release(8'h6B);
    key_release(8'h74);
    key_release(8'h2B);
    scancode = 8'h75;
    f0 = 1'b1;
    step();
    f0 = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("pushpop_count", int'(count), 4);
    check("pushpop_head", int'(cmd), 3);
    cmd_ready = 1'b1;
    step(); step(); step();
    cmd_ready = 1'b0;
    check("pushpop_tail", int'(cmd), 1);
    check("pushpop_tail_cnt", int'(count), 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;

    // Release while disabled, then enable later
    en = 1'b0;
    key_release(8'h75);
    check("dis_count", int'(count), 0);
    en = 1'b1;
    step();
    check("reen_count", int'(count), 0);

    // Pops continue while disabled
    key_release(8'h74);
    en = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    en = 1'b1;
    check("dis_pop_count", int'(count), 0);

    // Reset with three queued entries
    key_release(8'h72);
    key_release(8'h6B);
    key_release(8'h74);
    check("pre_rst_count", int'(count), 3);
    reset = 1'b1;
    f0 = 1'b1;
    scancode = 8'h75;
    step();
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_ovf", int'(ovf), 0);
    reset = 1'b0;
    f0 = 1'b0;
    step();
    check("post_rst_no_ev", int'(count), 0);

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       scancode = 8'h75;
        1:       scancode = 8'h72;
        2:       scancode = 8'h6B;
        3:       scancode = 8'h74;
        4:       scancode = 8'h2B;
        5:       scancode = 8'h2D;
        default: scancode = 8'($urandom_range(0, 255));
      endcase
      f0        = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 7) != 0);
      cmd_ready = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
